// File: rtl/laser_score.sv
// Scores a 40-point frame against two radius-4 circles: counts points inside either
// circle (SCORE) and inside both (OVL), one stored point per cycle after DONE rises.
module laser_score (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_done_in,
    input  logic [3:0] i_c1x,
    input  logic [3:0] i_c1y,
    input  logic [3:0] i_c2x,
    input  logic [3:0] i_c2y,
    output logic [5:0] o_score,
    output logic [5:0] o_ovl,
    output logic       o_score_valid,
    output logic       o_busy,
    output logic       o_err
);

    localparam logic [1:0] StLoad   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StScan   = 2'd2;
    localparam logic [1:0] StReport = 2'd3;

    localparam logic [5:0] LastIdx = 6'd39;

    logic [1:0] r_state;
    logic [5:0] r_ptr;
    logic       r_done_q;
    logic [5:0] r_score;
    logic [5:0] r_ovl;
    logic       r_err;
    logic [3:0] r_c1x, r_c1y, r_c2x, r_c2y;
    logic [7:0] r_mem [0:39];

    logic       w_rise;
    logic [3:0] w_px, w_py;
    logic       w_hit1, w_hit2;
    logic       w_store;

    // Squared distance is kept at 9 bits so far-away points never wrap into range.
    function automatic logic covered(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [8:0] d2;
        dx = (px >= cx) ? (px - cx) : (cx - px);
        dy = (py >= cy) ? (py - cy) : (cy - py);
        d2 = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
        return d2 <= 9'd16;
    endfunction

    always_comb begin
        w_rise  = i_done_in & ~r_done_q;
        w_px    = r_mem[r_ptr][7:4];
        w_py    = r_mem[r_ptr][3:0];
        w_hit1  = covered(w_px, w_py, r_c1x, r_c1y);
        w_hit2  = covered(w_px, w_py, r_c2x, r_c2y);
        w_store = (r_state == StLoad) && !w_rise && i_in_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StLoad;
            r_ptr    <= 6'd0;
            r_done_q <= 1'b1;
            r_score  <= 6'd0;
            r_ovl    <= 6'd0;
            r_err    <= 1'b0;
        end else begin
            r_done_q <= i_done_in;
            r_err    <= 1'b0;
            case (r_state)
                StLoad: begin
                    if (w_rise) begin
                        r_err <= 1'b1;
                        r_ptr <= 6'd0;
                    end else if (i_in_valid) begin
                        if (r_ptr == LastIdx) begin
                            r_ptr   <= 6'd0;
                            r_state <= StWait;
                        end else begin
                            r_ptr <= r_ptr + 6'd1;
                        end
                    end
                end
                StWait: begin
                    if (w_rise) begin
                        r_score <= 6'd0;
                        r_ovl   <= 6'd0;
                        r_ptr   <= 6'd0;
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    r_score <= r_score + 6'(w_hit1 | w_hit2);
                    r_ovl   <= r_ovl + 6'(w_hit1 & w_hit2);
                    if (r_ptr == LastIdx) begin
                        r_ptr   <= 6'd0;
                        r_state <= StReport;
                    end else begin
                        r_ptr <= r_ptr + 6'd1;
                    end
                end
                StReport: begin
                    r_ptr   <= 6'd0;
                    r_state <= StLoad;
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    // Point memory and latched centres need no reset; their contents are don't-care.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_store) begin
            r_mem[r_ptr] <= {i_x, i_y};
        end
        if (!i_rst && (r_state == StWait) && w_rise) begin
            r_c1x <= i_c1x;
            r_c1y <= i_c1y;
            r_c2x <= i_c2x;
            r_c2y <= i_c2y;
        end
    end

    always_comb begin
        o_score       = r_score;
        o_ovl         = r_ovl;
        o_score_valid = (r_state == StReport);
        o_busy        = (r_state == StScan) || (r_state == StReport);
        o_err         = r_err;
    end

endmodule
